piso_tx: RTL and testbench

Parallel-in serial-out transmitter that serialises a WIDTH-bit word onto a one-bit line, one bit per clock, MSB first. It is the transmit end for the team's serial-in parallel-out shift-register receiver. A valid/ready load handshake accepts words back-to-back with no idle gap. A frame-done strobe marks the last bit of each word.

---
 rtl/piso_tx.sv | 79 +++++++
 tb/tb_piso_tx.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// MSB-first parallel-in serial-out transmitter with a valid/ready load handshake.
// Build with PISO_TX_PARITY_EN defined to append an even-parity bit to every frame.
module piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pdata,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             frame_done
);

`ifdef PISO_TX_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    // Bits still to send after the one placed on sout at accept time.
    localparam int SH_W  = FRAME_LEN - 1;
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [SH_W-1:0]  shift_reg;
    logic [SH_W-1:0]  shift_load;
    logic             sout_reg;
    logic             sout_valid_reg;
    logic             last;
    logic             accept;

`ifdef PISO_TX_PARITY_EN
    // Parity is appended to the captured word, so later pdata changes cannot disturb it.
    assign shift_load = {pdata[WIDTH-2:0], ^pdata};
`else
    assign shift_load = pdata[WIDTH-2:0];
`endif

    assign last       = (state_reg == SHIFT) && (cnt_reg == CNT_W'(FRAME_LEN - 1));
    assign load_ready = (state_reg == IDLE) || last;
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            shift_reg      <= '0;
            sout_reg       <= 1'b0;
            sout_valid_reg <= 1'b0;
        end else if (accept) begin
            // The first bit goes out directly; the rest wait in shift_reg.
            state_reg      <= SHIFT;
            cnt_reg        <= '0;
            shift_reg      <= shift_load;
            sout_reg       <= pdata[WIDTH-1];
            sout_valid_reg <= 1'b1;
        end else if (last) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            sout_reg       <= 1'b0;
            sout_valid_reg <= 1'b0;
        end else if (state_reg == SHIFT) begin
            cnt_reg        <= cnt_reg + CNT_W'(1);
            shift_reg      <= shift_reg << 1;
            sout_reg       <= shift_reg[SH_W-1];
        end
    end

    assign sout       = sout_reg;
    assign sout_valid = sout_valid_reg;
    assign busy       = sout_valid_reg;
    assign frame_done = last;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed plan steps then random traffic,
// compared against a queue-of-pending-bits model plus a loopback receiver chain.
module tb_piso_tx;
    localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
    localparam int FRAME_LEN = W + 1;
`else
    localparam int FRAME_LEN = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] pdata = '0;
    logic         load_valid = 1'b0;
    logic         load_ready, sout, sout_valid, busy, frame_done;

    piso_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pdata      (pdata),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail = 0;
    bit           inited = 0;
    bit           q[$];          // bits still to appear on sout, q[0] is the current one
    logic [W-1:0] cur_word = '0;
    logic [W-1:0] rx = '0;       // receiver shift chain fed from sout
    bit           rx_pending = 0;
    logic [W-1:0] rx_exp = '0;

    task automatic check(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input logic r, input logic lv, input logic [W-1:0] pd);
        logic         o_sout, o_sv;
        int           pos;
        int           sz;
        logic [W-1:0] w;
        rst_n = r;
        load_valid = lv;
        pdata = pd;
        @(negedge clk);
        sz = q.size();
        if (inited) begin
            check("sout",       sout,       (sz > 0) ? q[0] : 1'b0);
            check("sout_valid", sout_valid, sz > 0);
            check("busy",       busy,       sz > 0);
            check("frame_done", frame_done, sz == 1);
            check("load_ready", load_ready, sz <= 1);
            if (rx_pending) begin
                check_w("rx_word", rx, rx_exp);
                rx_pending = 0;
            end
        end
        $display("t=%0t rst_n=%b lv=%b pdata=%b | sout=%b sv=%b fd=%b rdy=%b",
                 $time, r, lv, pd, sout, sout_valid, frame_done, load_ready);
        o_sout = sout;
        o_sv = sout_valid;
        pos = FRAME_LEN - sz;
        w = cur_word;
        @(posedge clk);
        if (o_sv) rx = {rx[W-2:0], o_sout};
        if (!r) begin
            q.delete();
            rx_pending = 0;
        end else begin
            if (sz > 0 && pos == W - 1) begin
                rx_pending = 1;
                rx_exp = w;
            end
            if (lv && sz <= 1) begin
                q.delete();
                for (int k = W - 1; k >= 0; k--) q.push_back(pd[k]);
`ifdef PISO_TX_PARITY_EN
                q.push_back(^pd);
`endif
                cur_word = pd;
            end else if (sz > 0) begin
                void'(q.pop_front());
            end
        end
        inited = 1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, W'($urandom));
    endtask

    initial begin
        // Reset with load_valid asserted
        step(1'b0, 1'b1, 4'b1010);
        step(1'b0, 1'b1, 4'b0101);
        idle(1);
        // Single word
        step(1'b1, 1'b1, 4'b1011);
        idle(6);
        // Back-to-back, load_valid held
        step(1'b1, 1'b1, 4'b1100);
        for (int i = 0; i < FRAME_LEN; i++) step(1'b1, 1'b1, 4'b0110);
        idle(FRAME_LEN + 2);
        // Load attempt while busy is ignored until the last bit
        step(1'b1, 1'b1, 4'b1011);
        step(1'b1, 1'b0, 4'b1011);
        for (int i = 0; i < FRAME_LEN - 1; i++) step(1'b1, 1'b1, 4'b0000);
        idle(FRAME_LEN + 2);
        // Reset mid-frame
        step(1'b1, 1'b1, 4'b1111);
        step(1'b1, 1'b0, 4'b1111);
        step(1'b0, 1'b0, 4'b1111);
        idle(2);
        step(1'b1, 1'b1, 4'b0101);
        idle(FRAME_LEN + 2);
        // Second parity pattern
        step(1'b1, 1'b1, 4'b1001);
        idle(FRAME_LEN + 2);
        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 1) == 1), W'($urandom));
        end
        idle(FRAME_LEN + 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
